// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops, iterative SHL_N and optional shift-add MUL.
// The multiplier (opcode 11) is built only when SEQ_ALU_MUL_EN is defined.
module seq_alu #(
  parameter int unsigned BUS_WIDTH          = 8,
  parameter int unsigned MUL_CYCLES_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 carry_in,
  input  logic [3:0]           opcode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic                 carry_out,
  output logic                 borrow,
  output logic                 zero,
  output logic                 parity,
  output logic                 invalid_op,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned ShW = $clog2(BUS_WIDTH);

  localparam logic [3:0] OpAdd      = 4'd1;
  localparam logic [3:0] OpAddCarry = 4'd2;
  localparam logic [3:0] OpSub      = 4'd3;
  localparam logic [3:0] OpInc      = 4'd4;
  localparam logic [3:0] OpDec      = 4'd5;
  localparam logic [3:0] OpAnd      = 4'd6;
  localparam logic [3:0] OpNot      = 4'd7;
  localparam logic [3:0] OpRol      = 4'd8;
  localparam logic [3:0] OpRor      = 4'd9;
  localparam logic [3:0] OpShl      = 4'd10;
`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OpMul      = 4'd11;
  localparam logic       PhaseLast  = 1'(MUL_CYCLES_PER_BIT - 1);
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q;
  logic [3:0]           op_q;
  logic [ShW-1:0]       cnt_q;
  logic [BUS_WIDTH-1:0] sh_q;

  logic [BUS_WIDTH-1:0] quick_y;
  logic                 quick_c;
  logic                 quick_b;
  logic                 quick_inv;
  logic [ShW-1:0]       shl_cnt;

`ifdef SEQ_ALU_MUL_EN
  logic [2*BUS_WIDTH-1:0] acc_q;
  logic [2*BUS_WIDTH-1:0] mcand_q;
  logic [BUS_WIDTH-1:0]   mplier_q;
  logic                   phase_q;
  logic [2*BUS_WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = acc_q;
    if (mplier_q[0]) acc_next = acc_q + mcand_q;
  end
`endif

  assign shl_cnt  = b[ShW-1:0];
  assign in_ready = (state_q == StIdle);
  assign zero     = (y == '0);
  assign parity   = ^y;

  // Result of every operation that retires on the accept edge; a zero-count SHL_N is a pass-through.
  always_comb begin
    quick_y   = '0;
    quick_c   = 1'b0;
    quick_b   = 1'b0;
    quick_inv = 1'b0;
    case (opcode)
      OpAdd:      quick_y = a + b;
      OpAddCarry: {quick_c, quick_y} = {1'b0, a} + {1'b0, b} + {{BUS_WIDTH{1'b0}}, carry_in};
      OpSub:      {quick_b, quick_y} = {1'b0, a} - {1'b0, b};
      OpInc:      {quick_c, quick_y} = {1'b0, a} + {{BUS_WIDTH{1'b0}}, 1'b1};
      OpDec:      {quick_b, quick_y} = {1'b0, a} - {{BUS_WIDTH{1'b0}}, 1'b1};
      OpAnd:      quick_y = a & b;
      OpNot:      quick_y = ~a;
      OpRol:      quick_y = {a[BUS_WIDTH-2:0], a[BUS_WIDTH-1]};
      OpRor:      quick_y = {a[0], a[BUS_WIDTH-1:1]};
      OpShl:      quick_y = a;
`ifdef SEQ_ALU_MUL_EN
      OpMul:      quick_y = '0;
`endif
      default:    quick_inv = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      y          <= '0;
      carry_out  <= 1'b0;
      borrow     <= 1'b0;
      invalid_op <= 1'b0;
      out_valid  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      phase_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q <= opcode;
            if (opcode == OpShl && shl_cnt != '0) begin
              state_q <= StBusy;
              sh_q    <= a;
              cnt_q   <= shl_cnt;
`ifdef SEQ_ALU_MUL_EN
            end else if (opcode == OpMul) begin
              state_q  <= StBusy;
              acc_q    <= '0;
              mcand_q  <= {{BUS_WIDTH{1'b0}}, a};
              mplier_q <= b;
              cnt_q    <= ShW'(BUS_WIDTH - 1);
              phase_q  <= 1'b0;
`endif
            end else begin
              state_q    <= StDone;
              y          <= quick_y;
              carry_out  <= quick_c;
              borrow     <= quick_b;
              invalid_op <= quick_inv;
              out_valid  <= 1'b1;
            end
          end
        end
        StBusy: begin
          case (op_q)
            OpShl: begin
              sh_q <= {sh_q[BUS_WIDTH-2:0], 1'b0};
              if (cnt_q == ShW'(1)) begin
                state_q    <= StDone;
                y          <= {sh_q[BUS_WIDTH-2:0], 1'b0};
                carry_out  <= sh_q[BUS_WIDTH-1];
                borrow     <= 1'b0;
                invalid_op <= 1'b0;
                out_valid  <= 1'b1;
              end else begin
                cnt_q <= cnt_q - ShW'(1);
              end
            end
`ifdef SEQ_ALU_MUL_EN
            OpMul: begin
              // One multiplier bit is consumed on the last phase of each bit slot.
              if (phase_q == PhaseLast) begin
                phase_q  <= 1'b0;
                acc_q    <= acc_next;
                mcand_q  <= {mcand_q[2*BUS_WIDTH-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[BUS_WIDTH-1:1]};
                if (cnt_q == '0) begin
                  state_q    <= StDone;
                  y          <= acc_next[BUS_WIDTH-1:0];
                  carry_out  <= |acc_next[2*BUS_WIDTH-1:BUS_WIDTH];
                  borrow     <= 1'b0;
                  invalid_op <= 1'b0;
                  out_valid  <= 1'b1;
                end else begin
                  cnt_q <= cnt_q - ShW'(1);
                end
              end else begin
                phase_q <= phase_q + 1'b1;
              end
            end
`endif
            default: state_q <= StIdle;
          endcase
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
// Expectations for opcode 11 follow whether SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic [3:0] opcode;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y;
  logic       carry_out;
  logic       borrow;
  logic       zero;
  logic       parity;
  logic       invalid_op;
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_errors = 0;

  seq_alu #(
    .BUS_WIDTH         (8),
    .MUL_CYCLES_PER_BIT(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .opcode    (opcode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .carry_out (carry_out),
    .borrow    (borrow),
    .zero      (zero),
    .parity    (parity),
    .invalid_op(invalid_op),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input int op, input int unsigned ai, input int unsigned bi,
                                input int unsigned ci, output int unsigned ey, output int ec,
                                output int eb, output int einv, output int elat);
    int unsigned full;
    int          n;
    ey = 0; ec = 0; eb = 0; einv = 0; elat = 0;
    case (op)
      1: ey = (ai + bi) % 256;
      2: begin full = ai + bi + ci; ey = full % 256; ec = (full >= 256) ? 1 : 0; end
      3: begin ey = (ai + 256 - bi) % 256; eb = (ai < bi) ? 1 : 0; end
      4: begin ey = (ai + 1) % 256; ec = (ai == 255) ? 1 : 0; end
      5: begin ey = (ai + 255) % 256; eb = (ai == 0) ? 1 : 0; end
      6: ey = ai & bi;
      7: ey = 255 - ai;
      8: ey = ((ai * 2) % 256) + (ai / 128);
      9: ey = (ai / 2) + ((ai % 2) * 128);
      10: begin
        n    = int'(bi % 8);
        full = ai << n;
        ey   = full % 256;
        ec   = (n == 0) ? 0 : int'((full / 256) % 2);
        elat = n;
      end
`ifdef SEQ_ALU_MUL_EN
      11: begin full = ai * bi; ey = full % 256; ec = (full >= 256) ? 1 : 0; elat = 8; end
`endif
      default: einv = 1;
    endcase
  endfunction

  task automatic run_op(input int op, input int unsigned ai, input int unsigned bi,
                        input int unsigned ci, input int hold);
    int unsigned ey;
    int          ec, eb, einv, elat, n, ez, ep;
    logic [7:0]  y_snap;
    model(op, ai, bi, ci, ey, ec, eb, einv, elat);
    ez = (ey == 0) ? 1 : 0;
    ep = $countones(ey) % 2;
    check("in_ready_idle", in_ready, 1);
    opcode   = 4'(op);
    a        = 8'(ai);
    b        = 8'(bi);
    carry_in = 1'(ci);
    in_valid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      check("in_ready_busy", in_ready, 0);
      in_valid = 1'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      carry_in = 1'($urandom);
      opcode   = 4'($urandom);
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency_op%0d", op), n, elat);
    check($sformatf("y_op%0d", op), y, ey);
    check($sformatf("carry_op%0d", op), carry_out, ec);
    check($sformatf("borrow_op%0d", op), borrow, eb);
    check($sformatf("zero_op%0d", op), zero, ez);
    check($sformatf("parity_op%0d", op), parity, ep);
    check($sformatf("invalid_op%0d", op), invalid_op, einv);
    y_snap = y;
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      opcode    = 4'($urandom_range(1, 9));
      a         = 8'($urandom);
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_y", y, y_snap);
      check("hold_carry", carry_out, ec);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retire_valid", out_valid, 0);
    check("retire_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    opcode    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_zero", zero, 1);
    check("rst_parity", parity, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1, 9, 33, 0, 0);
    run_op(2, 200, 100, 1, 0);
    run_op(3, 65, 66, 0, 0);
    run_op(10, 8'b0000_0011, 7, 0, 0);
    run_op(10, 8'b0000_0011, 0, 0, 0);
    run_op(11, 16, 17, 0, 0);
    run_op(4, 255, 0, 0, 5);
    run_op(5, 0, 0, 0, 0);

    // Reset in the middle of a multi-cycle operation, with a command offered during reset.
`ifdef SEQ_ALU_MUL_EN
    opcode = 4'd11;
`else
    opcode = 4'd10;
`endif
    a        = 8'd16;
    b        = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", in_ready, 0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    opcode   = 4'd1;
    a        = 8'd5;
    @(posedge clk); #1;
    check("abort_valid", out_valid, 0);
    check("abort_y", y, 0);
    check("abort_in_ready", in_ready, 1);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("no_accept_on_reset", out_valid, 0);
    run_op(0, 1, 2, 0, 0);

    for (int i = 0; i < 150; i++) begin
      run_op(int'($urandom_range(0, 15)), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 1), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
